// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Mode/pattern sequencer for the board LED bank, fed by debounced active-low keys.
// Detects key presses, keeps mode/speed/direction, and steps OFF/STATIC/BLINK/
// CHASE/BREATHE patterns on a prescaled tick.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   key_led   debounced LED keys, active-low: [0] faster, [1] slower, [2] dir toggle
//   key_mode  debounced mode key, active-low
//   led       LED drive, active-high, registered
//   mode      0 OFF, 1 STATIC, 2 BLINK, 3 CHASE, 4 BREATHE
//   speed     speed level 0..7 (steps take 8-speed ticks)
//   dir       chase direction, 0 = toward MSB, 1 = toward LSB
//
// Build option: define AUTO_CYCLE_EN to auto-advance the mode every AUTO_STEPS
// steps while in modes 1..4.
//
// state     | meaning
// M_OFF     | all LEDs off
// M_STATIC  | all LEDs on
// M_BLINK   | all LEDs follow blink phase, toggled per step
// M_CHASE   | one-hot position rotated per step
// M_BREATHE | PWM duty ramps 0..15..0, one value per step
module led_pattern_ctrl #(
    parameter int LED_W      = 8,
    parameter int TICK_DIV   = 50000,
    parameter int AUTO_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       key_led,
    input  logic             key_mode,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode,
    output logic [2:0]       speed,
    output logic             dir
);

    localparam int PW = $clog2(TICK_DIV);

    if (LED_W < 2 || TICK_DIV < 2 || AUTO_STEPS < 1) begin : g_param_check
        $error("led_pattern_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_STATIC  = 3'd1,
        M_BLINK   = 3'd2,
        M_CHASE   = 3'd3,
        M_BREATHE = 3'd4
    } mode_t;

    mode_t             mode_q, mode_key, mode_nxt;
    logic [2:0]        hist_led, press_led, speed_nxt;
    logic              hist_mode, press_mode, dir_nxt;
    logic [PW-1:0]     pre_cnt;
    logic [2:0]        step_cnt;
    logic              tick, key_change, change, step_fire;
    logic              phase, duty_down;
    logic [LED_W-1:0]  pos;
    logic [3:0]        duty, pwm_cnt;

    assign mode = mode_q;

    always_comb begin
        press_led  = hist_led & ~key_led;
        press_mode = hist_mode & ~key_mode;

        mode_key = mode_q;
        if (press_mode)
            mode_key = (mode_q == M_BREATHE) ? M_OFF : mode_t'(mode_q + 3'd1);

        // Opposing speed presses in one cycle cancel out.
        speed_nxt = speed;
        if (press_led[0] && !press_led[1] && speed != 3'd7)
            speed_nxt = speed + 3'd1;
        else if (press_led[1] && !press_led[0] && speed != 3'd0)
            speed_nxt = speed - 3'd1;

        dir_nxt    = dir ^ press_led[2];
        key_change = (mode_key != mode_q) || (speed_nxt != speed);
        tick       = (pre_cnt == PW'(TICK_DIV - 1));
        // A key-driven restart of the time base swallows a coincident step.
        step_fire  = tick && (step_cnt == 3'd7 - speed) && !key_change;
    end

`ifdef AUTO_CYCLE_EN
    localparam int AW = $clog2(AUTO_STEPS + 1);
    logic [AW-1:0] auto_cnt;
    logic          auto_adv;

    always_comb begin
        auto_adv = step_fire && (mode_q != M_OFF) && !(|press_led) && !press_mode
                   && (auto_cnt == AW'(AUTO_STEPS - 1));
        mode_nxt = mode_key;
        if (auto_adv)
            mode_nxt = (mode_q == M_BREATHE) ? M_STATIC : mode_t'(mode_q + 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            auto_cnt <= '0;
        else if ((|press_led) || press_mode || change)
            auto_cnt <= '0;
        else if (step_fire && mode_q != M_OFF)
            auto_cnt <= auto_cnt + 1'b1;
    end
`else
    assign mode_nxt = mode_key;
`endif

    assign change = (mode_nxt != mode_q) || (speed_nxt != speed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_led  <= 3'b111;
            hist_mode <= 1'b1;
            mode_q    <= M_OFF;
            speed     <= 3'd3;
            dir       <= 1'b0;
            pre_cnt   <= '0;
            step_cnt  <= '0;
            phase     <= 1'b1;
            pos       <= LED_W'(1);
            duty      <= 4'd0;
            duty_down <= 1'b0;
            pwm_cnt   <= 4'd0;
            led       <= '0;
        end else begin
            hist_led  <= key_led;
            hist_mode <= key_mode;
            mode_q    <= mode_nxt;
            speed     <= speed_nxt;
            dir       <= dir_nxt;
            pwm_cnt   <= pwm_cnt + 4'd1;

            if (change) begin
                pre_cnt  <= '0;
                step_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick)
                    step_cnt <= (step_cnt == 3'd7 - speed) ? 3'd0 : step_cnt + 3'd1;
            end

            if (mode_nxt != mode_q) begin
                case (mode_nxt)
                    M_BLINK:   phase <= 1'b1;
                    M_CHASE:   pos   <= dir_nxt ? {1'b1, {(LED_W-1){1'b0}}} : LED_W'(1);
                    M_BREATHE: begin
                        duty      <= 4'd0;
                        duty_down <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (step_fire) begin
                case (mode_q)
                    M_BLINK: phase <= ~phase;
                    M_CHASE: pos <= dir ? {pos[0], pos[LED_W-1:1]}
                                        : {pos[LED_W-2:0], pos[LED_W-1]};
                    M_BREATHE: begin
                        // Reversing at an end moves straight to the neighbour value,
                        // so 0 and 15 each last exactly one step.
                        if (!duty_down) begin
                            if (duty == 4'd15) begin
                                duty_down <= 1'b1;
                                duty      <= 4'd14;
                            end else begin
                                duty <= duty + 4'd1;
                            end
                        end else begin
                            if (duty == 4'd0) begin
                                duty_down <= 1'b0;
                                duty      <= 4'd1;
                            end else begin
                                duty <= duty - 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            case (mode_q)
                M_STATIC:  led <= '1;
                M_BLINK:   led <= {LED_W{phase}};
                M_CHASE:   led <= pos;
                M_BREATHE: led <= {LED_W{pwm_cnt < duty}};
                default:   led <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int AS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   key_led;
    logic         key_mode;
    logic [W-1:0] led;
    logic [2:0]   mode, speed;
    logic         dir;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.LED_W(W), .TICK_DIV(TD), .AUTO_STEPS(AS)) dut (
        .clk(clk), .rst(rst), .key_led(key_led), .key_mode(key_mode),
        .led(led), .mode(mode), .speed(speed), .dir(dir)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: e = cycles since last time-base restart (1 = first cycle),
    // cyc = cycles since reset (pwm phase), chase index, breathe triangle index.
    int         m_mode, m_speed, m_dir, m_phase, m_p, m_t, e, cyc, acnt;
    logic [2:0] h_led;
    logic       h_mode;
    int         m_led;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int duty_of(input int t);
        return (t <= 15) ? t : 30 - t;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 3; m_dir = 0; m_phase = 1; m_p = 0; m_t = 0;
        e = 1; cyc = 0; acnt = 0; h_led = 3'b111; h_mode = 1'b1; m_led = 0;
    endtask

    task automatic model_step();
        logic [2:0] pl;
        logic       pm;
        int         nm, ns, nd;
        bit         change, step;
        pl = h_led & ~key_led;
        pm = h_mode & ~key_mode;
        nm = pm ? (m_mode + 1) % 5 : m_mode;
        ns = m_speed;
        if (pl[0] && !pl[1] && ns < 7) ns++;
        if (pl[1] && !pl[0] && ns > 0) ns--;
        nd = pl[2] ? 1 - m_dir : m_dir;
        change = (nm != m_mode) || (ns != m_speed);
        step = !change && (e % (TD * (8 - m_speed)) == 0);
`ifdef AUTO_CYCLE_EN
        if (pl != 3'b000 || pm || change) acnt = 0;
        else if (step && m_mode != 0) begin
            acnt++;
            if (acnt == AS) begin
                acnt = 0;
                nm = (m_mode == 4) ? 1 : m_mode + 1;
                change = 1;
            end
        end
`endif
        case (m_mode)
            1: m_led = (1 << W) - 1;
            2: m_led = m_phase ? (1 << W) - 1 : 0;
            3: m_led = 1 << m_p;
            4: m_led = ((cyc % 16) < duty_of(m_t)) ? (1 << W) - 1 : 0;
            default: m_led = 0;
        endcase
        if (nm != m_mode) begin
            if (nm == 2) m_phase = 1;
            if (nm == 3) m_p = nd ? W - 1 : 0;
            if (nm == 4) m_t = 0;
        end else if (step) begin
            if (m_mode == 2) m_phase = 1 - m_phase;
            if (m_mode == 3) m_p = m_dir ? (m_p + W - 1) % W : (m_p + 1) % W;
            if (m_mode == 4) m_t = (m_t + 1) % 30;
        end
        e = change ? 1 : e + 1;
        cyc++;
        m_mode = nm; m_speed = ns; m_dir = nd;
        h_led = key_led; h_mode = key_mode;
    endtask

    task automatic check_all();
        chk("mode", mode, m_mode);
        chk("speed", speed, m_speed);
        chk("dir", dir, m_dir);
        chk("led", led, m_led);
    endtask

    task automatic apply(input logic [2:0] kl, input logic km);
        key_led = kl;
        key_mode = km;
        model_step();
    endtask

    task automatic tick(input logic [2:0] kl, input logic km);
        @(negedge clk);
        check_all();
        apply(kl, km);
    endtask

    task automatic hold(input logic [2:0] kl, input logic km, input int n);
        repeat (n) tick(kl, km);
    endtask

    task automatic press(input logic [2:0] kl, input logic km);
        hold(kl, km, 3);
        hold(3'b111, 1'b1, 3);
    endtask

    task automatic goto_mode(input int target);
        for (int i = 0; i < 8; i++)
            if (m_mode != target) press(3'b111, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        key_led = 3'b111;
        key_mode = 1'b1;
        #1;
        chk("rst_led_now", led, 0);
        chk("rst_mode_now", mode, 0);
        chk("rst_speed_now", speed, 3);
        chk("rst_dir_now", dir, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(3'b111, 1'b1);
    endtask

    initial begin
        int seq[5];
        int w;
        logic [2:0] kl;
        logic       km;
        seq = '{1, 2, 3, 4, 0};
        rst = 1'b1;
        key_led = 3'b111;
        key_mode = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_mode", mode, 0);
        chk("reset_speed", speed, 3);
        chk("reset_dir", dir, 0);
        chk("reset_led", led, 0);
        rst = 1'b0;
        apply(3'b111, 1'b1);

        hold(3'b111, 1'b1, 30);
        chk("idle_led", led, 0);
        chk("idle_mode", mode, 0);

        for (int k = 0; k < 5; k++) begin
            tick(3'b111, 1'b0);
            tick(3'b111, 1'b0);
            chk("mode_seq", mode, seq[k]);
            tick(3'b111, 1'b0);
            if (k == 0) chk("static_led", led, 8'hFF);
            hold(3'b111, 1'b0, 7);
            hold(3'b111, 1'b1, 10);
        end

        goto_mode(2);
        hold(3'b111, 1'b1, 60);
        repeat (4) press(3'b110, 1'b1);
        chk("speed_sat", speed, 7);
        hold(3'b111, 1'b1, 40);

`ifndef AUTO_CYCLE_EN
        goto_mode(3);
        chk("chase_mode", mode, 3);
        w = 0;
        while (led !== 8'h10 && w < 200) begin
            tick(3'b111, 1'b1);
            w++;
        end
        chk("wait_led10", led, 8'h10);
        hold(3'b011, 1'b1, 3);
        w = 0;
        while (led === 8'h10 && w < 20) begin
            tick(3'b011, 1'b1);
            w++;
        end
        chk("chase_reverse", led, 8'h08);
        hold(3'b111, 1'b1, 40);
`endif

        goto_mode(4);
        hold(3'b111, 1'b1, 300);
        tick(3'b100, 1'b1);
        tick(3'b100, 1'b1);
        chk("speed_both_keys", speed, 7);
        hold(3'b111, 1'b1, 5);

`ifdef AUTO_CYCLE_EN
        do_reset();
        repeat (4) press(3'b110, 1'b1);
        press(3'b111, 1'b0);
        hold(3'b111, 1'b1, 10);
        chk("auto_not_yet", mode, 1);
        hold(3'b111, 1'b1, 15);
        chk("auto_advanced", mode, 2);
`endif

        goto_mode(3);
        hold(3'b111, 1'b1, 8);
        do_reset();

        kl = 3'b111;
        km = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 60) kl[$urandom_range(0, 2)] = ~kl[$urandom_range(0, 2)] | kl[0] & 1'b0;
            else if (r < 64) km = ~km;
            else if (r == 999 && $urandom_range(0, 9) == 0) begin
                do_reset();
                kl = 3'b111;
                km = 1'b1;
            end
            tick(kl, km);
        end
        hold(3'b111, 1'b1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
